// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the PC, drives the combinational
// ROM address and registers the returned word into an IR with a valid/ready
// handshake towards the decoder. It handles stall, branch redirect with flush,
// PC wrap-around and an optional halt state.
// Optional feature: define FETCH_HALT_EN to stop fetching on HALT_INSTR.
module fetch_unit #(
    parameter int unsigned                ADDR_W     = 4,
    parameter int unsigned                INSTR_W    = 8,
    parameter logic [ADDR_W-1:0]          RESET_PC   = '0,
    parameter logic [INSTR_W-1:0]         HALT_INSTR = 8'h38
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_instr,
    output logic [INSTR_W-1:0] ir_instr,
    output logic [ADDR_W-1:0]  ir_pc,
    output logic               ir_valid,
    input  logic               ir_ready,
    input  logic               branch_en,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               pc_wrap,
    output logic               halted
);

`ifdef FETCH_HALT_EN
    localparam logic HALT_EN = 1'b1;
`else
    localparam logic HALT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_HALT = 2'b01
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [INSTR_W-1:0]  ir_instr_q, ir_instr_d;
    logic [ADDR_W-1:0]   ir_pc_q, ir_pc_d;
    logic                ir_valid_q, ir_valid_d;
    logic                pc_wrap_q, pc_wrap_d;
    logic                halted_q, halted_d;
    logic                load;
    logic                halt_hit;

    // The ROM address is the PC register itself, with no logic on the path.
    assign mem_addr = pc_q;
    assign ir_instr = ir_instr_q;
    assign ir_pc    = ir_pc_q;
    assign ir_valid = ir_valid_q;
    assign pc_wrap  = pc_wrap_q;
    assign halted   = halted_q;

    // Next-state logic: fetch/load, drain in HALT, then branch overrides everything.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_instr_d = ir_instr_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        halted_d   = halted_q;
        pc_wrap_d  = 1'b0;

        load     = (state_q == ST_RUN) && (!ir_valid_q || ir_ready) && !branch_en;
        halt_hit = HALT_EN && (mem_instr == HALT_INSTR);

        case (state_q)
            ST_RUN: begin
                if (load) begin
                    ir_instr_d = mem_instr;
                    ir_pc_d    = pc_q;
                    ir_valid_d = 1'b1;
                    if (halt_hit) begin
                        // PC stays on the halt word; no increment, so no wrap pulse.
                        state_d  = ST_HALT;
                        halted_d = 1'b1;
                    end else begin
                        pc_d      = pc_q + 1'b1;
                        pc_wrap_d = (pc_q == '1);
                    end
                end
            end
            ST_HALT: begin
                if (ir_valid_q && ir_ready) begin
                    ir_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (branch_en) begin
            pc_d       = branch_target;
            ir_valid_d = 1'b0;
            pc_wrap_d  = 1'b0;
            state_d    = ST_RUN;
            halted_d   = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            ir_instr_q <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
            pc_wrap_q  <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_instr_q <= ir_instr_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            pc_wrap_q  <= pc_wrap_d;
            halted_q   <= halted_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit. Accepted IR words are
// checked against a queue of hand-computed (instruction, address) pairs;
// flags and stall/flush/reset behaviour are checked inline.
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] mem_addr;
    logic [7:0] mem_instr;
    logic [7:0] ir_instr;
    logic [3:0] ir_pc;
    logic       ir_valid;
    logic       ir_ready;
    logic       branch_en;
    logic [3:0] branch_target;
    logic       pc_wrap;
    logic       halted;

    logic [7:0]  rom [16];
    logic [11:0] exp_q [$];
    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    assign mem_instr = rom[mem_addr];

    fetch_unit #(
        .ADDR_W    (4),
        .INSTR_W   (8),
        .RESET_PC  (4'h0),
        .HALT_INSTR(8'h38)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_addr     (mem_addr),
        .mem_instr    (mem_instr),
        .ir_instr     (ir_instr),
        .ir_pc        (ir_pc),
        .ir_valid     (ir_valid),
        .ir_ready     (ir_ready),
        .branch_en    (branch_en),
        .branch_target(branch_target),
        .pc_wrap      (pc_wrap),
        .halted       (halted)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] ins, input logic [3:0] pc);
        exp_q.push_back({ins, pc});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every word the decoder accepts must match the next expected entry.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && ir_valid === 1'b1 && ir_ready === 1'b1 && branch_en === 1'b0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_accept", {20'h0, ir_instr, ir_pc}, 32'hFFFF_FFFF);
            end else begin
                chk("accept_instr_pc", {20'h0, ir_instr, ir_pc}, {20'h0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        rom[0]  = 8'h1C; rom[1]  = 8'h02; rom[2]  = 8'h01; rom[3]  = 8'h13;
        rom[4]  = 8'hB0; rom[5]  = 8'h38; rom[6]  = 8'h46; rom[7]  = 8'h57;
        rom[8]  = 8'h68; rom[9]  = 8'h79; rom[10] = 8'h8A; rom[11] = 8'h9B;
        rom[12] = 8'hAC; rom[13] = 8'hBD; rom[14] = 8'hCE; rom[15] = 8'hDF;

        rst_n = 1'b0; ir_ready = 1'b1; branch_en = 1'b0; branch_target = 4'h0;
        step(); step();
        chk("rst_valid",    ir_valid, 0);
        chk("rst_instr",    ir_instr, 0);
        chk("rst_pc",       ir_pc,    0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_wrap",     pc_wrap,  0);
        chk("rst_halted",   halted,   0);

        // Streaming at one instruction per cycle.
        push(8'h1C, 4'h0); push(8'h02, 4'h1); push(8'h01, 4'h2); push(8'h13, 4'h3);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("stream_valid", ir_valid, 1);
        end
        chk("stream_last_instr", ir_instr, 8'hB0);
        chk("stream_last_pc",    ir_pc,    4'h4);
        rst_n = 1'b0;
        step();
        chk("rst2_valid", ir_valid, 0);

        // Stall while IR holds 02.
        rst_n = 1'b1;
        push(8'h1C, 4'h0);
        step();
        step();
        ir_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_instr", ir_instr, 8'h02);
            chk("stall_pc",    ir_pc,    4'h1);
            chk("stall_addr",  mem_addr, 4'h2);
            chk("stall_valid", ir_valid, 1);
        end
        ir_ready = 1'b1;
        push(8'h02, 4'h1); push(8'h01, 4'h2);
        step();
        step();
        ir_ready = 1'b0;
        chk("pre_branch_instr", ir_instr, 8'h13);
        chk("pre_branch_pc",    ir_pc,    4'h3);

        // Branch to A while IR is valid and stalled: flush plus one bubble.
        branch_en = 1'b1; branch_target = 4'hA;
        step();
        chk("branch_flush_valid", ir_valid, 0);
        chk("branch_addr",        mem_addr, 4'hA);
        chk("branch_wrap",        pc_wrap,  0);
        branch_en = 1'b0; ir_ready = 1'b1;

        // Run A..F, wrap to 0..5; pc_wrap only while IR holds the word from F.
        for (int a = 10; a < 22; a++) push(rom[a % 16], 4'(a % 16));
        for (int k = 0; k < 12; k++) begin
            step();
            chk("run_valid", ir_valid, 1);
            chk("run_wrap",  pc_wrap,  (k == 5) ? 1 : 0);
        end
        chk("op38_instr", ir_instr, 8'h38);
        chk("op38_pc",    ir_pc,    4'h5);
`ifdef FETCH_HALT_EN
        chk("halt_flag",  halted,   1);
        chk("halt_addr",  mem_addr, 4'h5);
        for (int k = 0; k < 2; k++) begin
            step();
            chk("halt_drained", ir_valid, 0);
            chk("halt_held",    halted,   1);
            chk("halt_addr2",   mem_addr, 4'h5);
        end
        ir_ready = 1'b0;
`else
        chk("nohalt_flag", halted,   0);
        chk("nohalt_addr", mem_addr, 4'h6);
        step();
        ir_ready = 1'b0;
        chk("nohalt_next_instr", ir_instr, 8'h46);
        chk("nohalt_next_pc",    ir_pc,    4'h6);
        chk("nohalt_flag2",      halted,   0);
`endif
        branch_en = 1'b1; branch_target = 4'h0;
        step();
        chk("exit_halted", halted,   0);
        chk("exit_addr",   mem_addr, 4'h0);
        chk("exit_valid",  ir_valid, 0);
        branch_en = 1'b0; ir_ready = 1'b1;
        push(8'h1C, 4'h0);
        step();
        step();
        ir_ready = 1'b0;
        chk("self_br_pre_instr", ir_instr, 8'h02);
        chk("self_br_pre_addr",  mem_addr, 4'h2);

        // Branch to the current PC refetches the same address.
        branch_en = 1'b1; branch_target = 4'h2;
        step();
        chk("self_br_addr",  mem_addr, 4'h2);
        chk("self_br_valid", ir_valid, 0);
        branch_en = 1'b0; ir_ready = 1'b1;
        push(8'h01, 4'h2);
        step();
        step();
        ir_ready = 1'b0;
        chk("pre_rst_instr", ir_instr, 8'h13);
        step();
        chk("pre_rst_stall", ir_pc, 4'h3);

        // Reset in the middle of a stall discards the IR.
        rst_n = 1'b0;
        step();
        chk("mid_rst_valid",  ir_valid, 0);
        chk("mid_rst_instr",  ir_instr, 0);
        chk("mid_rst_addr",   mem_addr, 0);
        chk("mid_rst_halted", halted,   0);
        step();
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
